// File: rtl/rmt_action_pkg.sv
// Shared definitions for the RMT action stage: opcodes, action word layout, issue FSM states.
package rmt_action_pkg;

    // Action word field widths and bit positions
    localparam int unsigned OP_W       = 4;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned OP_MSB     = 24;
    localparam int unsigned OP_LSB     = 21;
    localparam int unsigned SRC1_MSB   = 20;
    localparam int unsigned SRC1_LSB   = 16;
    localparam int unsigned SRC2_MSB   = 15;
    localparam int unsigned SRC2_LSB   = 11;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned MAX_STAGES = 32;

    // Type-2 ALU opcodes
    localparam logic [OP_W-1:0] OP_NOP   = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OP_W-1:0] OP_STORE = 4'b1000;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SUBI  = 4'b1010;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Opcodes whose second operand is the zero-extended immediate
    function automatic logic op_uses_imm(input logic [OP_W-1:0] op);
        logic res;
        res = 1'b0;
        case (op)
            OP_ADD, OP_SUB:                      res = 1'b0;
            OP_STORE, OP_ADDI, OP_SUBI, OP_LOAD: res = 1'b1;
            default:                             res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/phv_container_sel.sv
// NUM_CONT:1 PHV container mux; indices beyond the last container select zero.
module phv_container_sel
    import rmt_action_pkg::*;
#(
    parameter int unsigned NUM_CONT   = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [NUM_CONT*DATA_WIDTH-1:0] i_phv,
    input  logic [IDX_W-1:0]               i_idx,
    output logic [DATA_WIDTH-1:0]          o_data_c
);

    // Compare against every legal index so out-of-range indices fall through to zero
    always_comb begin
        o_data_c = '0;
        for (int i = 0; i < int'(NUM_CONT); i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_data_c = i_phv[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Per-ALU issue/writeback controller: holds one PHV, issues one action, writes the result back.
module alu_issue_ctrl
    import rmt_action_pkg::*;
#(
    parameter int unsigned STAGE_ID   = 0,
    parameter int unsigned ALU_ID     = 0,
    parameter int unsigned ACTION_LEN = 25,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CONT   = 8,
    parameter int unsigned PHV_WIDTH  = 256,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PHV_WIDTH-1:0]  phv_in,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACTION_LEN-1:0] alu_action,
    output logic                  alu_action_valid,
    output logic [DATA_WIDTH-1:0] alu_operand_1,
    output logic [DATA_WIDTH-1:0] alu_operand_2,
    output logic [DATA_WIDTH-1:0] alu_operand_3,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_result_valid,
    output logic [PHV_WIDTH-1:0]  phv_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    // Reject parameter sets the container layout or action format cannot support
    if (PHV_WIDTH != NUM_CONT * DATA_WIDTH || ALU_ID >= NUM_CONT || STAGE_ID >= MAX_STAGES ||
        ACTION_LEN != OP_MSB + 1 || DATA_WIDTH < IMM_W || TIMEOUT == 0) begin : g_cfg_err
        $error("alu_issue_ctrl: inconsistent parameter set");
    end

    state_t                r_state;
    logic                  r_in_ready;
    logic [ACTION_LEN-1:0] r_action;
    logic                  r_action_valid;
    logic [DATA_WIDTH-1:0] r_operand_1;
    logic [DATA_WIDTH-1:0] r_operand_2;
    logic [DATA_WIDTH-1:0] r_operand_3;
    logic [PHV_WIDTH-1:0]  r_phv;
    logic [PHV_WIDTH-1:0]  r_phv_out;
    logic                  r_out_valid;
    logic                  r_timeout_err;
    logic [CNT_W-1:0]      r_cnt;

    logic [OP_W-1:0]       w_op;
    logic [IDX_W-1:0]      w_src1;
    logic [IDX_W-1:0]      w_src2;
    logic [IMM_W-1:0]      w_imm;
    logic [DATA_WIDTH-1:0] w_cont_src1;
    logic [DATA_WIDTH-1:0] w_cont_src2;
    logic [DATA_WIDTH-1:0] w_cont_dst;
    logic [DATA_WIDTH-1:0] w_operand_2;
    logic [PHV_WIDTH-1:0]  w_phv_wb;

    // Decode fields of the incoming action word
    assign w_op   = action_in[OP_MSB:OP_LSB];
    assign w_src1 = action_in[SRC1_MSB:SRC1_LSB];
    assign w_src2 = action_in[SRC2_MSB:SRC2_LSB];
    assign w_imm  = action_in[IMM_MSB:IMM_LSB];

    phv_container_sel #(.NUM_CONT(NUM_CONT), .DATA_WIDTH(DATA_WIDTH)) u_sel_src1 (
        .i_phv    (phv_in),
        .i_idx    (w_src1),
        .o_data_c (w_cont_src1)
    );

    phv_container_sel #(.NUM_CONT(NUM_CONT), .DATA_WIDTH(DATA_WIDTH)) u_sel_src2 (
        .i_phv    (phv_in),
        .i_idx    (w_src2),
        .o_data_c (w_cont_src2)
    );

    phv_container_sel #(.NUM_CONT(NUM_CONT), .DATA_WIDTH(DATA_WIDTH)) u_sel_dst (
        .i_phv    (phv_in),
        .i_idx    (IDX_W'(ALU_ID)),
        .o_data_c (w_cont_dst)
    );

    // Immediate opcodes (including load/store addressing) take the zero-extended immediate
    assign w_operand_2 = op_uses_imm(w_op) ? DATA_WIDTH'(w_imm) : w_cont_src2;

    // Held PHV with this ALU's destination container replaced by the result
    always_comb begin
        w_phv_wb = r_phv;
        w_phv_wb[ALU_ID*DATA_WIDTH +: DATA_WIDTH] = alu_result;
    end

    // Issue/wait/output FSM; phv_out is always reloaded from the held PHV before out_valid rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_in_ready     <= 1'b1;
            r_action       <= '0;
            r_action_valid <= 1'b0;
            r_operand_1    <= '0;
            r_operand_2    <= '0;
            r_operand_3    <= '0;
            r_phv          <= '0;
            r_phv_out      <= '0;
            r_out_valid    <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_cnt          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_phv       <= phv_in;
                        r_action    <= action_in;
                        r_operand_1 <= w_cont_src1;
                        r_operand_2 <= w_operand_2;
                        r_operand_3 <= w_cont_dst;
                        r_in_ready  <= 1'b0;
                        if (w_op == OP_NOP) begin
                            r_state <= ST_OUT;
                        end else begin
                            r_action_valid <= 1'b1;
                            r_state        <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_action_valid <= 1'b0;
                    r_cnt          <= '0;
                    r_state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_result_valid) begin
                        r_phv_out   <= w_phv_wb;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_phv_out     <= r_phv;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_OUT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (!r_out_valid) begin
                        r_phv_out   <= r_phv;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready         = r_in_ready;
    assign alu_action       = r_action;
    assign alu_action_valid = r_action_valid;
    assign alu_operand_1    = r_operand_1;
    assign alu_operand_2    = r_operand_2;
    assign alu_operand_3    = r_operand_3;
    assign phv_out          = r_phv_out;
    assign out_valid        = r_out_valid;
    assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a 3-cycle ALU model and a PHV scoreboard.
module tb_alu_issue_ctrl;

    logic         clk;
    logic         rst_n;
    logic [255:0] phv_in;
    logic [24:0]  action_in;
    logic         in_valid;
    logic         in_ready;
    logic [24:0]  alu_action;
    logic         alu_action_valid;
    logic [31:0]  alu_operand_1;
    logic [31:0]  alu_operand_2;
    logic [31:0]  alu_operand_3;
    logic [31:0]  alu_result;
    logic         alu_result_valid;
    logic [255:0] phv_out;
    logic         out_valid;
    logic         out_ready;
    logic         timeout_err;

    int           n_vec = 0;
    int           n_err = 0;
    int           n_pulse = 0;
    bit           alu_en = 1'b1;
    int           stray_req = 0;
    int           stray_seen = 0;
    logic [255:0] exp_q[$];

    alu_issue_ctrl #(
        .STAGE_ID   (0),
        .ALU_ID     (0),
        .ACTION_LEN (25),
        .DATA_WIDTH (32),
        .NUM_CONT   (8),
        .PHV_WIDTH  (256),
        .TIMEOUT    (15)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phv_in           (phv_in),
        .action_in        (action_in),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .alu_action       (alu_action),
        .alu_action_valid (alu_action_valid),
        .alu_operand_1    (alu_operand_1),
        .alu_operand_2    (alu_operand_2),
        .alu_operand_3    (alu_operand_3),
        .alu_result       (alu_result),
        .alu_result_valid (alu_result_valid),
        .phv_out          (phv_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .timeout_err      (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Type-2 ALU behaviour; load returns a synthetic memory word derived from the address
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c);
        case (op)
            4'b0001, 4'b1001: return a + b;
            4'b0010, 4'b1010: return a - b;
            4'b1011:          return 32'h1000_0000 | b;
            4'b1000:          return c;
            default:          return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] cont(input logic [255:0] p, input logic [4:0] idx);
        if (idx < 5'd8) return p[idx*32 +: 32];
        return 32'h0;
    endfunction

    // Expected phv_out for a bundle; alu_on=0 models an ALU that never answers
    function automatic logic [255:0] exp_phv(input logic [255:0] p, input logic [24:0] a,
                                             input bit alu_on);
        logic [3:0]   op;
        logic [31:0]  b;
        logic [255:0] r;
        op = a[24:21];
        if (op == 4'b1000 || op == 4'b1001 || op == 4'b1010 || op == 4'b1011)
            b = {16'h0, a[15:0]};
        else
            b = cont(p, a[15:11]);
        r = p;
        if (op != 4'b0000 && alu_on)
            r[31:0] = ref_alu(op, cont(p, a[20:16]), b, cont(p, 5'd0));
        return r;
    endfunction

    // ALU model: answers three cycles after the issue pulse; also injects stray strobes on request
    initial begin
        logic [31:0] res;
        alu_result       = 32'h0;
        alu_result_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_action_valid === 1'b1 && alu_en) begin
                res = ref_alu(alu_action[24:21], alu_operand_1, alu_operand_2, alu_operand_3);
                repeat (3) @(posedge clk);
                #1;
                alu_result       = res;
                alu_result_valid = 1'b1;
                @(posedge clk);
                #1;
                alu_result_valid = 1'b0;
            end else if (stray_req != stray_seen) begin
                stray_seen       = stray_seen + 1;
                alu_result       = 32'h0BAD_0BAD;
                alu_result_valid = 1'b1;
                @(negedge clk);
                alu_result_valid = 1'b0;
            end
        end
    end

    // Count issue pulses, one per cycle they are high
    initial begin
        forever begin
            @(posedge clk);
            if (alu_action_valid === 1'b1) n_pulse = n_pulse + 1;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, observed time %0t expected < 50000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bundle for exactly one accepted cycle and record its expected output
    task automatic send(input logic [255:0] p, input logic [24:0] a, input bit alu_on);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 256'(in_ready), 256'(1));
        phv_in    = p;
        action_in = a;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        exp_q.push_back(exp_phv(p, a, alu_on));
    endtask

    // Called one cycle after accept; lat counts cycles from accept to first out_valid
    task automatic expect_out(input string tag, input int lat_exp, input int max);
        int           lat = 1;
        logic [255:0] e;
        while (out_valid !== 1'b1 && lat < max) begin
            tick();
            lat++;
        end
        chk({tag, "_valid"}, 256'(out_valid), 256'(1));
        chk({tag, "_lat"}, 256'(lat), 256'(lat_exp));
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_phv"}, phv_out, e);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 256'(out_valid), 256'(0));
        chk({tag, "_drain_ready"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
        logic [255:0] p;
        logic [255:0] p2;
        logic [255:0] snap;
        logic [24:0]  a_add;
        logic [24:0]  a_subi;
        int           p0;
        bit           stable_ok;

        p      = {32'h77, 32'h66, 32'h55, 32'h4444, 32'h7, 32'h5, 32'h10, 32'hA0};
        p2     = {32'h1, 32'h2, 32'h3, 32'h4, 32'h17, 32'h64, 32'h9, 32'h8};
        a_add  = {4'b0001, 5'd2, 5'd3, 11'd0};
        a_subi = {4'b1010, 5'd2, 16'h0001};

        rst_n     = 1'b0;
        phv_in    = '0;
        action_in = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_issue", 256'(alu_action_valid), 256'(0));
        chk("rst_timeout", 256'(timeout_err), 256'(0));
        chk("rst_phv_out", phv_out, 256'(0));
        chk("rst_operand_1", 256'(alu_operand_1), 256'(0));
        rst_n = 1'b1;
        tick();

        // ADD c2+c3 into c0
        p0 = n_pulse;
        send(p, a_add, 1'b1);
        chk("add_ready_low", 256'(in_ready), 256'(0));
        expect_out("add", 5, 20);
        chk("add_pulses", 256'(n_pulse - p0), 256'(1));
        chk("add_op1", 256'(alu_operand_1), 256'(32'h5));
        chk("add_op2", 256'(alu_operand_2), 256'(32'h7));
        chk("add_op3", 256'(alu_operand_3), 256'(32'hA0));
        chk("add_action", 256'(alu_action), 256'(a_add));
        drain("add");

        // ADDI: immediate operand
        send(p, {4'b1001, 5'd1, 16'h0020}, 1'b1);
        expect_out("addi", 5, 20);
        chk("addi_op1", 256'(alu_operand_1), 256'(32'h10));
        chk("addi_op2", 256'(alu_operand_2), 256'(32'h20));
        drain("addi");

        // LOAD: address comes from the immediate
        send(p, {4'b1011, 5'd0, 16'h0003}, 1'b1);
        expect_out("load", 5, 20);
        chk("load_op2", 256'(alu_operand_2), 256'(32'h3));
        drain("load");

        // SUB with out-of-range src1 reads zero
        send(p, {4'b0010, 5'd9, 5'd3, 11'd0}, 1'b1);
        expect_out("sub_oor", 5, 20);
        chk("sub_oor_op1", 256'(alu_operand_1), 256'(0));
        drain("sub_oor");

        // NOP bypass: no issue, PHV unchanged
        p0 = n_pulse;
        send(p2, {4'b0000, 21'h1ABCD}, 1'b1);
        expect_out("nop", 2, 20);
        chk("nop_pulses", 256'(n_pulse - p0), 256'(0));
        drain("nop");

        // Backpressure with a competing bundle held on the input
        send(p, a_add, 1'b1);
        expect_out("bp", 5, 20);
        phv_in    = p2;
        action_in = a_subi;
        in_valid  = 1'b1;
        stable_ok = 1'b1;
        snap      = phv_out;
        repeat (10) begin
            tick();
            if (phv_out !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) stable_ok = 1'b0;
        end
        chk("bp_stable", 256'(stable_ok), 256'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_ready_after_out", 256'(in_ready), 256'(1));
        chk("bp_out_dropped", 256'(out_valid), 256'(0));
        tick();
        in_valid = 1'b0;
        exp_q.push_back(exp_phv(p2, a_subi, 1'b1));
        chk("bp_second_accepted", 256'(in_ready), 256'(0));
        expect_out("bp2", 5, 20);
        drain("bp2");

        // Timeout: ALU silent
        alu_en = 1'b0;
        p0 = n_pulse;
        send(p, a_add, 1'b0);
        expect_out("to", 17, 40);
        chk("to_err", 256'(timeout_err), 256'(1));
        chk("to_pulses", 256'(n_pulse - p0), 256'(1));
        drain("to");
        alu_en = 1'b1;
        stray_req = stray_req + 1;
        repeat (4) tick();
        chk("stray_out_valid", 256'(out_valid), 256'(0));
        chk("stray_in_ready", 256'(in_ready), 256'(1));
        chk("stray_phv", phv_out, p);
        chk("stray_err_sticky", 256'(timeout_err), 256'(1));

        // Asynchronous reset in the middle of WAIT
        send(p, a_add, 1'b1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 256'(out_valid), 256'(0));
        chk("arst_issue", 256'(alu_action_valid), 256'(0));
        chk("arst_timeout", 256'(timeout_err), 256'(0));
        chk("arst_phv_out", phv_out, 256'(0));
        chk("arst_op2", 256'(alu_operand_2), 256'(0));
        chk("arst_action", 256'(alu_action), 256'(0));
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("arst_in_ready", 256'(in_ready), 256'(1));
        chk("arst_idle_out", 256'(out_valid), 256'(0));
        send(p2, a_add, 1'b1);
        expect_out("arst_add", 5, 20);
        chk("arst_add_op1", 256'(alu_operand_1), 256'(32'h64));
        drain("arst_add");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
